// File: rtl/wash_ctrl_fsm_if.sv
// Washing-machine controller bus: start/pause requests, timer handshake
// and status. master = stimulus side, slave = controller side.
interface wash_ctrl_fsm_if;
  logic       i_coin;
  logic       i_double_wash;
  logic       i_timer_pause;
  logic       i_timer_done;
  logic       o_timer_en;
  logic [1:0] o_timer_num;
  logic [2:0] o_state;
  logic       o_busy;
  logic       o_wash_done;

  modport master (
    output i_coin,
    output i_double_wash,
    output i_timer_pause,
    output i_timer_done,
    input  o_timer_en,
    input  o_timer_num,
    input  o_state,
    input  o_busy,
    input  o_wash_done
  );

  modport slave (
    input  i_coin,
    input  i_double_wash,
    input  i_timer_pause,
    input  i_timer_done,
    output o_timer_en,
    output o_timer_num,
    output o_state,
    output o_busy,
    output o_wash_done
  );
endinterface

// File: rtl/wash_ctrl_fsm.sv
// Wash cycle sequencer: IDLE->FILL->WASH->RINSE(->WASH->RINSE)->SPIN->IDLE.
// Ports: clk, rst (async, active-low), bus (wash_ctrl_fsm_if.slave):
//   i_coin, i_double_wash, i_timer_pause, i_timer_done in;
//   o_timer_en, o_timer_num, o_state, o_busy, o_wash_done out (registered).
// Option: define WASH_DOUBLE_EN for the double-wash RINSE->WASH loop.
module wash_ctrl_fsm #(
  parameter logic [1:0] FILL_UNITS  = 2'd1,
  parameter logic [1:0] WASH_UNITS  = 2'd2,
  parameter logic [1:0] RINSE_UNITS = 2'd2,
  parameter logic [1:0] SPIN_UNITS  = 2'd1
) (
  input logic          clk,
  input logic          rst,
  wash_ctrl_fsm_if.slave bus
);

  // A zero-length phase would never see a done pulse; force at least one unit.
  localparam logic [1:0] FILL_N  =
    (FILL_UNITS == 2'd0) ? 2'd1 : FILL_UNITS;
  localparam logic [1:0] WASH_N  =
    (WASH_UNITS == 2'd0) ? 2'd1 : WASH_UNITS;
  localparam logic [1:0] RINSE_N =
    (RINSE_UNITS == 2'd0) ? 2'd1 : RINSE_UNITS;
  localparam logic [1:0] SPIN_N  =
    (SPIN_UNITS == 2'd0) ? 2'd1 : SPIN_UNITS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4
  } state_t;

  state_t     state_q;
  logic       done_q;
  logic       en_q;
  logic [1:0] num_q;
  logic       busy_q;
  logic       wdone_q;
  logic       adv;

`ifdef WASH_DOUBLE_EN
  logic       pass_q;
`else
  logic       unused_dw;
  assign unused_dw = bus.i_double_wash;
`endif

  // Advance on the falling edge of done: the timer has cleared its
  // count by then, so the next phase starts from zero.
  assign adv = done_q & ~bus.i_timer_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      num_q   <= 2'd0;
      busy_q  <= 1'b0;
      wdone_q <= 1'b0;
`ifdef WASH_DOUBLE_EN
      pass_q  <= 1'b0;
`endif
    end else begin
      done_q  <= bus.i_timer_done;
      wdone_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.i_coin) begin
            state_q <= S_FILL;
            en_q    <= 1'b1;
            num_q   <= FILL_N;
            busy_q  <= 1'b1;
`ifdef WASH_DOUBLE_EN
            pass_q  <= bus.i_double_wash;
`endif
          end
        end
        S_FILL: begin
          if (adv) begin
            state_q <= S_WASH;
            num_q   <= WASH_N;
          end
        end
        S_WASH: begin
          if (adv) begin
            state_q <= S_RINSE;
            num_q   <= RINSE_N;
          end
        end
        S_RINSE: begin
          if (adv) begin
`ifdef WASH_DOUBLE_EN
            if (pass_q) begin
              state_q <= S_WASH;
              num_q   <= WASH_N;
              pass_q  <= 1'b0;
            end else begin
              state_q <= S_SPIN;
              num_q   <= SPIN_N;
            end
`else
            state_q <= S_SPIN;
            num_q   <= SPIN_N;
`endif
          end
        end
        S_SPIN: begin
          if (adv) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            num_q   <= 2'd0;
            busy_q  <= 1'b0;
            wdone_q <= 1'b1;
          end else begin
            // Pause only gates the timer during spin.
            en_q    <= ~bus.i_timer_pause;
          end
        end
        default: begin
          state_q <= S_IDLE;
          en_q    <= 1'b0;
          num_q   <= 2'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_state     = state_q;
  assign bus.o_timer_en  = en_q;
  assign bus.o_timer_num = num_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_wash_done = wdone_q;

endmodule

// File: tb/tb_wash_ctrl_fsm.sv
// Randomized bench for wash_ctrl_fsm against a phase-queue model.
// Scenario tasks run in sequence; one summary line at the end.
module tb_wash_ctrl_fsm;

  logic clk;
  logic rst;
  wash_ctrl_fsm_if bus ();

  wash_ctrl_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: queue of phases still to run; head is the current phase.
  int         m_ph[$];
  logic       m_dq;
  logic       m_en;
  logic       m_wd;
  logic [2:0] m_state;
  logic [1:0] m_num;
  logic [1:0] unit_tab [5];
  logic [7:0] exp_v;
  logic [7:0] act;

  int         tr_q[$];
  int         wd_cnt;
  int         enlow_cnt;
  logic [2:0] last_st;

  assign act = {bus.o_state, bus.o_timer_en, bus.o_timer_num,
                bus.o_busy, bus.o_wash_done};

  task automatic model_out();
    m_state = (m_ph.size() == 0) ? 3'd0 : 3'(m_ph[0]);
    m_num   = unit_tab[m_state];
    exp_v   = {m_state, m_en, m_num, (m_state != 3'd0), m_wd};
  endtask

  task automatic model_reset();
    m_ph.delete();
    m_dq = 1'b0;
    m_en = 1'b0;
    m_wd = 1'b0;
    model_out();
  endtask

  task automatic drive(input logic c, input logic dw,
                       input logic p, input logic d);
    bus.i_coin        = c;
    bus.i_double_wash = dw;
    bus.i_timer_pause = p;
    bus.i_timer_done  = d;
  endtask

  task automatic tick();
    logic adv;
    @(posedge clk);
    adv  = m_dq && !bus.i_timer_done;
    m_dq = bus.i_timer_done;
    m_wd = 1'b0;
    if (m_ph.size() == 0) begin
      if (bus.i_coin) begin
        m_ph.push_back(1);
        m_ph.push_back(2);
        m_ph.push_back(3);
`ifdef WASH_DOUBLE_EN
        if (bus.i_double_wash) begin
          m_ph.push_back(2);
          m_ph.push_back(3);
        end
`endif
        m_ph.push_back(4);
        m_en = 1'b1;
      end
    end else if (adv) begin
      void'(m_ph.pop_front());
      m_en = (m_ph.size() != 0);
      m_wd = (m_ph.size() == 0);
    end else if (m_ph[0] == 4) begin
      m_en = !bus.i_timer_pause;
    end
    model_out();
    #1;
  endtask

  task automatic note();
    if (bus.o_state !== last_st) begin
      tr_q.push_back(int'(bus.o_state));
      last_st = bus.o_state;
    end
    if (bus.o_wash_done === 1'b1) wd_cnt++;
    if (bus.o_timer_en === 1'b0) enlow_cnt++;
  endtask

  task automatic clr_trace();
    tr_q.delete();
    wd_cnt    = 0;
    enlow_cnt = 0;
    last_st   = bus.o_state;
  endtask

  task automatic cycles(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s t=%0t dut=%b model=%b",
                 nm, $time, act, exp_v);
      end
      note();
    end
  endtask

  task automatic run_pulses(input int n, input int len,
                            input string nm);
    for (int i = 0; i < n; i++) begin
      bus.i_timer_done = 1'b1;
      cycles(len, nm);
      bus.i_timer_done = 1'b0;
      cycles($urandom_range(1, 3), nm);
    end
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    #12;
    checks++;
    if (act !== 8'd0) begin
      errors++;
      $display("FAIL reset dut=%b want=%b", act, 8'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    cycles(3, "reset_idle");
  endtask

  task automatic test_single();
    int want[$];
    want = '{1, 2, 3, 4, 0};
    clr_trace();
    drive(1, 0, 0, 0);
    cycles(1, "single");
    drive(0, 0, 0, 0);
    run_pulses(4, 10, "single");
    checks++;
    if (tr_q != want) begin
      errors++;
      $display("FAIL single_trace dut=%p want=%p", tr_q, want);
    end
    checks++;
    if (wd_cnt != 1) begin
      errors++;
      $display("FAIL single_done dut=%0d want=1", wd_cnt);
    end
  endtask

  task automatic test_double();
    int want[$];
    int np;
`ifdef WASH_DOUBLE_EN
    want = '{1, 2, 3, 2, 3, 4, 0};
    np = 6;
`else
    want = '{1, 2, 3, 4, 0};
    np = 4;
`endif
    clr_trace();
    drive(1, 1, 0, 0);
    cycles(1, "double");
    drive(0, 0, 0, 0);
    run_pulses(np, 10, "double");
    checks++;
    if (tr_q != want) begin
      errors++;
      $display("FAIL double_trace dut=%p want=%p", tr_q, want);
    end
    checks++;
    if (wd_cnt != 1) begin
      errors++;
      $display("FAIL double_done dut=%0d want=1", wd_cnt);
    end
  endtask

  task automatic test_spin_pause();
    drive(1, 0, 0, 0);
    cycles(1, "spin_pause");
    drive(0, 0, 0, 0);
    run_pulses(3, 5, "spin_pause");
    clr_trace();
    bus.i_timer_pause = 1'b1;
    cycles(20, "spin_pause");
    checks++;
    if (enlow_cnt != 20 || bus.o_state !== 3'd4) begin
      errors++;
      $display("FAIL spin_hold enlow=%0d st=%0d want 20/4",
               enlow_cnt, bus.o_state);
    end
    bus.i_timer_pause = 1'b0;
    run_pulses(1, 5, "spin_pause");
    checks++;
    if (bus.o_state !== 3'd0) begin
      errors++;
      $display("FAIL spin_end st=%0d want=0", bus.o_state);
    end
  endtask

  task automatic test_wash_ignore();
    drive(1, 0, 0, 0);
    cycles(1, "wash_ign");
    drive(0, 0, 0, 0);
    run_pulses(1, 4, "wash_ign");
    clr_trace();
    drive(1, 1, 1, 0);
    cycles(8, "wash_ign");
    checks++;
    if (enlow_cnt != 0 || bus.o_state !== 3'd2) begin
      errors++;
      $display("FAIL wash_ign enlow=%0d st=%0d want 0/2",
               enlow_cnt, bus.o_state);
    end
    drive(0, 0, 0, 0);
    run_pulses(3, 4, "wash_ign");
  endtask

  task automatic test_idle_done();
    clr_trace();
    drive(0, 0, 0, 0);
    run_pulses(2, 6, "idle_done");
    checks++;
    if (bus.o_state !== 3'd0 || wd_cnt != 0) begin
      errors++;
      $display("FAIL idle_done st=%0d wd=%0d want 0/0",
               bus.o_state, wd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int want[$];
    want = '{1, 2, 3, 4, 0, 1};
    clr_trace();
    drive(1, 0, 0, 0);
    cycles(1, "b2b");
    run_pulses(4, 4, "b2b");
    cycles(2, "b2b");
    checks++;
    if (tr_q != want) begin
      errors++;
      $display("FAIL b2b_trace dut=%p want=%p", tr_q, want);
    end
    drive(0, 0, 0, 0);
    run_pulses(4, 4, "b2b");
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0);
    cycles(1, "rst_mid");
    drive(0, 0, 0, 0);
    run_pulses(2, 4, "rst_mid");
    bus.i_timer_done = 1'b1;
    cycles(3, "rst_mid");
    checks++;
    if (bus.o_state !== 3'd3) begin
      errors++;
      $display("FAIL rst_mid_pre st=%0d want=3", bus.o_state);
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid dut=%b want=%b", act, 8'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.i_timer_done = 1'b0;
    cycles(6, "rst_after");
    checks++;
    if (bus.o_state !== 3'd0) begin
      errors++;
      $display("FAIL rst_after st=%0d want=0", bus.o_state);
    end
  endtask

  task automatic test_random();
    int hi_left  = 0;
    int gap_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hi_left > 0) begin
        bus.i_timer_done = 1'b1;
        hi_left--;
      end else if (gap_left > 0) begin
        bus.i_timer_done = 1'b0;
        gap_left--;
      end else begin
        bus.i_timer_done = 1'b0;
        hi_left  = $urandom_range(1, 6);
        gap_left = $urandom_range(0, 4);
      end
      bus.i_coin        = ($urandom_range(0, 5) == 0);
      bus.i_double_wash = $urandom_range(0, 1) == 1;
      bus.i_timer_pause = ($urandom_range(0, 3) == 0);
      cycles(1, "random");
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    unit_tab[0] = 2'd0;
    unit_tab[1] = 2'd1;
    unit_tab[2] = 2'd2;
    unit_tab[3] = 2'd2;
    unit_tab[4] = 2'd1;
    test_reset();
    test_single();
    test_double();
    test_spin_pause();
    test_wash_ignore();
    test_idle_done();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wash_ctrl_fsm.md
# wash_ctrl_fsm

Washing-machine cycle controller that sequences FILL, WASH, RINSE and SPIN phases. It sits directly upstream of the phase timer: it drives the timer's enable and unit-count inputs and consumes the timer's done pulse to advance phases. It accepts a coin/start request, an optional double-wash request, and a spin-pause input, and reports cycle completion.

## Interface
- FILL_UNITS, 2'd1, FILL phase length in timer units (1..3)
- WASH_UNITS, 2'd2, WASH phase length in timer units (1..3)
- RINSE_UNITS, 2'd2, RINSE phase length in timer units (1..3)
- SPIN_UNITS, 2'd1, SPIN phase length in timer units (1..3)
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- i_coin  input  1  start request; level, sampled only in IDLE
- i_double_wash  input  1  request second WASH+RINSE pass; sampled with accepted coin
- i_timer_pause  input  1  pause request; honoured only in SPIN
- i_timer_done  input  1  timer done pulse (multi-cycle high)
- o_timer_en  output  1  timer count enable
- o_timer_num  output  2  current phase length in units
- o_state  output  3  0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 SPIN
- o_busy  output  1  high when state != IDLE
- o_wash_done  output  1  one-cycle completion pulse

## Operation
- All outputs registered. Reset: state IDLE, o_timer_en 0, o_timer_num 0, o_busy 0, o_wash_done 0, pass flag 0, done_q 0.
- Phase advance event `adv` = done_q & ~i_timer_done (falling edge of done pulse); done_q is i_timer_done delayed one cycle. Rising edge and pulse body ignored. The timer clears its count at pulse end, so advancing on the falling edge gives the next phase a clean count from zero.
- Transitions:
  - IDLE -> FILL on i_coin; latch pass flag = i_double_wash.
  - FILL -> WASH on adv.
  - WASH -> RINSE on adv.
  - RINSE -> WASH on adv if pass flag = 1; clear pass flag.
  - RINSE -> SPIN on adv if pass flag = 0.
  - SPIN -> IDLE on adv; o_wash_done = 1 for exactly that cycle.
- o_timer_num = FILL/WASH/RINSE/SPIN_UNITS of the entered phase, updated on the same edge as the state. IDLE holds the value 0.
- o_timer_en = 1 in FILL, WASH, RINSE; in SPIN = ~i_timer_pause (registered); 0 in IDLE.
- o_timer_en stays high across phase boundaries; no idle cycle is inserted between phases.
- Parameter value 0 is replaced by 1 at elaboration.

## Timing
- Coin sampled high at edge k in IDLE: at k, state=FILL, o_timer_en=1, o_timer_num=FILL_UNITS, o_busy=1.
- i_timer_done sampled 1 at edge j and 0 at edge j+1: state advances at edge j+1. Latency from done falling to new state is one edge.
- Pause sampled high in SPIN at edge p: o_timer_en=0 at p. Pause sampled low at edge q: o_timer_en=1 at q. Pause outside SPIN has no effect.
- Pause during an active done pulse in SPIN: the timer freezes with the pulse high. adv occurs on the falling edge after resume.
- adv in IDLE is ignored. i_coin while busy is ignored. i_double_wash is ignored except at coin acceptance.
- Coin held high through SPIN->IDLE: the new cycle starts on the next edge (IDLE lasts one cycle).
- Async reset mid-cycle: immediate return to reset values. A partial pulse is discarded (done_q cleared).

## Configuration
- WASH_DOUBLE_EN defined: double-wash pass flag and RINSE->WASH loop are present.
- WASH_DOUBLE_EN undefined: i_double_wash is ignored (port retained), pass flag is omitted, and RINSE always goes to SPIN.

## Test plan
- Reset then i_coin=1 for 1 cycle, i_double_wash=0, four 10-cycle done pulses -> states 1,2,3,4,0. o_timer_num goes 1,2,2,1,0. o_wash_done high for exactly 1 cycle at the final fall.
- Same with i_double_wash=1 and WASH_DOUBLE_EN defined -> states 1,2,3,2,3,4,0 over six pulses. Without the macro -> 1,2,3,4,0.
- In SPIN, raise i_timer_pause for 20 cycles -> o_timer_en 0 for those 20 cycles and state stays 4. After release, the next done fall -> IDLE.
- In WASH, assert i_timer_pause and i_coin -> no effect; o_timer_en stays 1 and state stays 2.
- In IDLE, apply a done pulse without coin -> state stays 0 and o_wash_done stays 0.
- Assert rst low mid-RINSE while done is high -> all outputs 0 at once. After release with no coin, the state remains IDLE.
